wb_write_queue: RTL and testbench

- Writeback-side producer for the integer register file: collects results from two execution sources and drives the register file write port (RegWr/Rw/busW) at most one write per cycle.
- Up to two results are enqueued per cycle into an in-order buffer, which drains one entry per cycle into the register file.
- Optionally provides a forwarding lookup, so the register read stage can see results that are still queued.

---
 rtl/wb_write_queue.sv | 116 +++++++++++
 tb/tb_wb_write_queue.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_queue.sv
// Writeback write queue: merges two result sources into the single register file write port.
// Optional WB_FWD_EN adds a combinational lookup of queued results for the read stage.
module wb_write_queue #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4  // power of two, >= 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s0_valid,
    input  logic [ADDR_W-1:0]          s0_rd,
    input  logic [DATA_W-1:0]          s0_data,
    output logic                       s0_ready,
    input  logic                       s1_valid,
    input  logic [ADDR_W-1:0]          s1_rd,
    input  logic [DATA_W-1:0]          s1_data,
    output logic                       s1_ready,
    output logic                       reg_wr,
    output logic [ADDR_W-1:0]          rw,
    output logic [DATA_W-1:0]          bus_w,
    input  logic [ADDR_W-1:0]          fwd_addr,
    output logic                       fwd_hit,
    output logic [DATA_W-1:0]          fwd_data,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wrPtr, rdPtr;
    logic [CNT_W-1:0]   occ;
    logic               rrPri;   // 0: source 0 wins the next contended slot

    logic               nonEmpty, pop;
    logic [CNT_W-1:0]   free;
    logic               need0, need1, contend;
    logic               rdy0, rdy1, push0, push1;
    logic [PTR_W-1:0]   wrPtr1;

    assign nonEmpty = (occ != '0);
    assign pop      = nonEmpty;
    // The head leaves this cycle, so its slot is already usable by an incoming result.
    assign free     = CNT_W'(DEPTH) - occ + CNT_W'(nonEmpty);
    assign need0    = s0_valid && (s0_rd != '0);
    assign need1    = s1_valid && (s1_rd != '0);
    assign contend  = (free == CNT_W'(1)) && need0 && need1;

    always_comb begin
        rdy0 = 1'b0;
        rdy1 = 1'b0;
        if (rst) begin
            rdy0 = 1'b0;
            rdy1 = 1'b0;
        end else if (free >= CNT_W'(2)) begin
            rdy0 = 1'b1;
            rdy1 = 1'b1;
        end else if (free == CNT_W'(1)) begin
            // x0 writes take no slot, so they never cause contention.
            rdy0 = s0_valid && (!contend || !rrPri);
            rdy1 = s1_valid && (!contend ||  rrPri);
        end
    end

    assign s0_ready = rdy0;
    assign s1_ready = rdy1;
    assign push0    = need0 && rdy0;
    assign push1    = need1 && rdy1;
    assign wrPtr1   = wrPtr + PTR_W'(push0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            occ   <= '0;
            rrPri <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push0) mem[wrPtr]  <= '{rd: s0_rd, data: s0_data};
            if (push1) mem[wrPtr1] <= '{rd: s1_rd, data: s1_data};
            wrPtr <= wrPtr + PTR_W'(push0) + PTR_W'(push1);
            rdPtr <= rdPtr + PTR_W'(pop);
            occ   <= occ - CNT_W'(pop) + CNT_W'(push0) + CNT_W'(push1);
            if (contend) rrPri <= ~rrPri;
        end
    end

    assign count  = occ;
    assign reg_wr = nonEmpty;
    assign rw     = nonEmpty ? mem[rdPtr].rd   : '0;
    assign bus_w  = nonEmpty ? mem[rdPtr].data : '0;

`ifdef WB_FWD_EN
    // Walk oldest to youngest so the last match is the youngest.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < occ) && (fwd_addr != '0) &&
                (mem[rdPtr + PTR_W'(i)].rd == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = mem[rdPtr + PTR_W'(i)].data;
            end
        end
    end
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
    wire unusedFwd = ^fwd_addr;
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue: reset, single/dual push, contention fill, x0 drop, forwarding, async reset.
module tb_wb_write_queue;
    logic        clk, rst;
    logic        s0_valid, s1_valid, s0_ready, s1_ready;
    logic [4:0]  s0_rd, s1_rd, rw, fwd_addr;
    logic [63:0] s0_data, s1_data, bus_w, fwd_data;
    logic        reg_wr, fwd_hit;
    logic [2:0]  count;

    int tests = 0;
    int fails = 0;

    wb_write_queue #(.DATA_W(64), .ADDR_W(5), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .s0_valid(s0_valid), .s0_rd(s0_rd), .s0_data(s0_data), .s0_ready(s0_ready),
        .s1_valid(s1_valid), .s1_rd(s1_rd), .s1_data(s1_data), .s1_ready(s1_ready),
        .reg_wr(reg_wr), .rw(rw), .bus_w(bus_w),
        .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        s0_valid = 0; s1_valid = 0;
        s0_rd = 0; s1_rd = 0; s0_data = 0; s1_data = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle(); fwd_addr = 0;
        @(negedge clk);
        tests++; if (reg_wr !== 1'b0 || count !== 3'd0) begin fails++;
            $display("FAIL reset_state: reg_wr=%0b count=%0d want 0 0", reg_wr, count); end
        tests++; if (rw !== 5'd0 || bus_w !== 64'd0 || fwd_hit !== 1'b0) begin fails++;
            $display("FAIL reset_outputs: rw=%0d bus_w=%0h fwd_hit=%0b want 0", rw, bus_w, fwd_hit); end
        s0_valid = 1; s1_valid = 1; s0_rd = 1; s1_rd = 2;
        #1;
        tests++; if (s0_ready !== 1'b0 || s1_ready !== 1'b0) begin fails++;
            $display("FAIL reset_ready: %0b%0b want 00", s0_ready, s1_ready); end
        idle();
        rst = 0;
    endtask

    task automatic test_single_push();
        @(negedge clk);
        s0_valid = 1; s0_rd = 5; s0_data = 64'hAA;
        #1;
        tests++; if (s0_ready !== 1'b1) begin fails++;
            $display("FAIL single_ready: got %0b want 1", s0_ready); end
        @(negedge clk); idle();
        tests++; if (reg_wr !== 1'b1 || rw !== 5'd5 || bus_w !== 64'hAA || count !== 3'd1) begin fails++;
            $display("FAIL single_write: reg_wr=%0b rw=%0d bus_w=%0h count=%0d want 1 5 aa 1", reg_wr, rw, bus_w, count); end
        @(negedge clk);
        tests++; if (reg_wr !== 1'b0 || count !== 3'd0 || rw !== 5'd0) begin fails++;
            $display("FAIL single_drained: reg_wr=%0b count=%0d rw=%0d want 0 0 0", reg_wr, count, rw); end
    endtask

    task automatic test_dual_push();
        @(negedge clk);
        s0_valid = 1; s0_rd = 3; s0_data = 64'h11;
        s1_valid = 1; s1_rd = 3; s1_data = 64'h22;
        #1;
        tests++; if (s0_ready !== 1'b1 || s1_ready !== 1'b1) begin fails++;
            $display("FAIL dual_ready: %0b%0b want 11", s0_ready, s1_ready); end
        @(negedge clk); idle();
        tests++; if (reg_wr !== 1'b1 || rw !== 5'd3 || bus_w !== 64'h11 || count !== 3'd2) begin fails++;
            $display("FAIL dual_first: reg_wr=%0b rw=%0d bus_w=%0h count=%0d want 1 3 11 2", reg_wr, rw, bus_w, count); end
        @(negedge clk);
        tests++; if (reg_wr !== 1'b1 || rw !== 5'd3 || bus_w !== 64'h22 || count !== 3'd1) begin fails++;
            $display("FAIL dual_second: reg_wr=%0b rw=%0d bus_w=%0h count=%0d want 1 3 22 1", reg_wr, rw, bus_w, count); end
        @(negedge clk);
        tests++; if (reg_wr !== 1'b0 || count !== 3'd0) begin fails++;
            $display("FAIL dual_drained: reg_wr=%0b count=%0d want 0 0", reg_wr, count); end
    endtask

    // Both sources stream for 10 cycles; expected readies are hand-derived:
    // free = 4,3,2 for the first three cycles, then 1 with round-robin s0,s1,s0,...
    task automatic test_fill_contention();
        logic [4:0]  qRd[$];
        logic [63:0] qData[$];
        logic        e0, e1;
        int          errs = 0;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            tests++;
            if (count !== 3'(qRd.size())) begin
                errs++; fails++;
                $display("FAIL fill_count c=%0d: got %0d want %0d", c, count, qRd.size());
            end else if (qRd.size() != 0) begin
                if (reg_wr !== 1'b1 || rw !== qRd[0] || bus_w !== qData[0]) begin
                    errs++; fails++;
                    $display("FAIL fill_head c=%0d: reg_wr=%0b rw=%0d bus_w=%0h want 1 %0d %0h",
                             c, reg_wr, rw, bus_w, qRd[0], qData[0]);
                end
            end else if (reg_wr !== 1'b0) begin
                errs++; fails++;
                $display("FAIL fill_idle c=%0d: reg_wr=%0b want 0", c, reg_wr);
            end
            if (qRd.size() != 0) begin void'(qRd.pop_front()); void'(qData.pop_front()); end
            if (c < 10) begin
                s0_valid = 1; s0_rd = 5'(c + 1);  s0_data = 64'h100 + 64'(c);
                s1_valid = 1; s1_rd = 5'(c + 16); s1_data = 64'h200 + 64'(c);
                #1;
                e0 = (c < 3) || ((c - 3) % 2 == 0);
                e1 = (c < 3) || ((c - 3) % 2 == 1);
                tests++;
                if (s0_ready !== e0 || s1_ready !== e1) begin
                    errs++; fails++;
                    $display("FAIL fill_ready c=%0d: got %0b%0b want %0b%0b", c, s0_ready, s1_ready, e0, e1);
                end
                if (e0) begin qRd.push_back(s0_rd); qData.push_back(s0_data); end
                if (e1) begin qRd.push_back(s1_rd); qData.push_back(s1_data); end
            end else begin
                idle();
            end
        end
        tests++; if (qRd.size() != 0) begin fails++;
            $display("FAIL fill_drain: %0d entries never written", qRd.size()); end
    endtask

    task automatic test_x0_drop();
        @(negedge clk);
        s1_valid = 1; s1_rd = 0; s1_data = 64'hFF;
        #1;
        tests++; if (s1_ready !== 1'b1) begin fails++;
            $display("FAIL x0_ready: got %0b want 1", s1_ready); end
        @(negedge clk); idle();
        tests++; if (reg_wr !== 1'b0 || count !== 3'd0) begin fails++;
            $display("FAIL x0_drop: reg_wr=%0b count=%0d want 0 0", reg_wr, count); end
        // x0 alongside a real write: only the real one lands
        s0_valid = 1; s0_rd = 9; s0_data = 64'h33;
        s1_valid = 1; s1_rd = 0; s1_data = 64'hFF;
        @(negedge clk); idle();
        tests++; if (reg_wr !== 1'b1 || rw !== 5'd9 || bus_w !== 64'h33 || count !== 3'd1) begin fails++;
            $display("FAIL x0_mixed: reg_wr=%0b rw=%0d bus_w=%0h count=%0d want 1 9 33 1", reg_wr, rw, bus_w, count); end
        @(negedge clk);
        tests++; if (reg_wr !== 1'b0 || count !== 3'd0) begin fails++;
            $display("FAIL x0_mixed_drain: reg_wr=%0b count=%0d want 0 0", reg_wr, count); end
    endtask

    task automatic test_fwd();
        logic        expHit;
        logic [63:0] expData;
        @(negedge clk);
        s0_valid = 1; s0_rd = 7; s0_data = 64'h1;
        s1_valid = 1; s1_rd = 7; s1_data = 64'h2;
        @(negedge clk); idle();
        fwd_addr = 7;
        #1;
`ifdef WB_FWD_EN
        expHit = 1'b1; expData = 64'h2;
`else
        expHit = 1'b0; expData = 64'h0;
`endif
        tests++; if (count !== 3'd2 || fwd_hit !== expHit || fwd_data !== expData) begin fails++;
            $display("FAIL fwd_youngest: count=%0d hit=%0b data=%0h want 2 %0b %0h", count, fwd_hit, fwd_data, expHit, expData); end
        fwd_addr = 0;
        #1;
        tests++; if (fwd_hit !== 1'b0) begin fails++;
            $display("FAIL fwd_x0: hit=%0b want 0", fwd_hit); end
        fwd_addr = 7;
        @(negedge clk);
        tests++; if (count !== 3'd1 || fwd_hit !== expHit || fwd_data !== expData) begin fails++;
            $display("FAIL fwd_head: count=%0d hit=%0b data=%0h want 1 %0b %0h", count, fwd_hit, fwd_data, expHit, expData); end
        fwd_addr = 6;
        #1;
        tests++; if (fwd_hit !== 1'b0) begin fails++;
            $display("FAIL fwd_miss: hit=%0b want 0", fwd_hit); end
        fwd_addr = 0;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        s0_valid = 1; s0_rd = 4; s0_data = 64'h40;
        s1_valid = 1; s1_rd = 5; s1_data = 64'h50;
        @(negedge clk);
        s0_rd = 6; s0_data = 64'h60;
        s1_rd = 8; s1_data = 64'h80;
        @(negedge clk);
        tests++; if (count !== 3'd3 || reg_wr !== 1'b1) begin fails++;
            $display("FAIL areset_pre: count=%0d reg_wr=%0b want 3 1", count, reg_wr); end
        #2 rst = 1;
        #1;
        tests++; if (reg_wr !== 1'b0 || count !== 3'd0 || rw !== 5'd0) begin fails++;
            $display("FAIL areset_now: reg_wr=%0b count=%0d rw=%0d want 0 0 0", reg_wr, count, rw); end
        tests++; if (s0_ready !== 1'b0 || s1_ready !== 1'b0) begin fails++;
            $display("FAIL areset_ready: %0b%0b want 00", s0_ready, s1_ready); end
        idle();
        @(negedge clk);
        rst = 0;
        test_single_push();
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_dual_push();
        test_fill_contention();
        test_x0_drop();
        test_fwd();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end
endmodule
